// File: rtl/keccak_sponge_ctrl.sv
// Sequencer for a one-round-per-cycle Keccak-f[1600] datapath: clear, absorb one
// pre-padded rate block lane by lane, then permute/squeeze a programmable number of blocks.
module keccak_sponge_ctrl #(
  parameter int STATE_WIDTH      = 1600,
  parameter int RATE             = 1344,
  parameter int N_R              = 24,
  parameter int LANE_WIDTH       = STATE_WIDTH / 25,
  parameter int BLK_CNT_W        = 16,
  parameter int SEED_LANES       = RATE / LANE_WIDTH,
  parameter int CNT_LENGTH_ROUND = $clog2(N_R)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start_i,
  input  logic [BLK_CNT_W-1:0]        num_blocks_i,
  input  logic                        din_valid_i,
  output logic                        din_ready_o,
  output logic                        state_clear_o,
  output logic                        absorb_en_o,
  output logic [4:0]                  absorb_sel_o,
  output logic                        round_en_o,
  output logic [CNT_LENGTH_ROUND-1:0] round_idx_o,
  output logic                        dout_valid_o,
  input  logic                        dout_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  // state     | meaning
  // S_IDLE    | waiting for start_i
  // S_CLEAR   | one-cycle state zeroing
  // S_ABSORB  | XOR SEED_LANES lanes in, one per handshake
  // S_PERMUTE | N_R consecutive rounds
  // S_SQUEEZE | rate block valid, wait for downstream
  // S_DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ABSORB, S_PERMUTE, S_SQUEEZE, S_DONE
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [4:0]                  r_lane, w_lane_nxt;
  logic [CNT_LENGTH_ROUND-1:0] r_round, w_round_nxt;
  logic [BLK_CNT_W-1:0]        r_blk_cnt, w_blk_cnt_nxt;
  logic [BLK_CNT_W-1:0]        r_blk_tgt, w_blk_tgt_nxt;
  logic                        w_last_lane, w_last_round, w_last_blk;

  assign w_last_lane  = (r_lane == 5'(SEED_LANES - 1));
  assign w_last_round = (r_round == CNT_LENGTH_ROUND'(N_R - 1));
  // blk_tgt is never 0, so the subtraction cannot wrap even at the maximum count
  assign w_last_blk   = (r_blk_cnt == (r_blk_tgt - BLK_CNT_W'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_round   <= '0;
      r_blk_cnt <= '0;
      r_blk_tgt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lane    <= w_lane_nxt;
      r_round   <= w_round_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
      r_blk_tgt <= w_blk_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lane_nxt    = r_lane;
    w_round_nxt   = r_round;
    w_blk_cnt_nxt = r_blk_cnt;
    w_blk_tgt_nxt = r_blk_tgt;
    din_ready_o   = 1'b0;
    state_clear_o = 1'b0;
    absorb_en_o   = 1'b0;
    absorb_sel_o  = '0;
    round_en_o    = 1'b0;
    round_idx_o   = '0;
    dout_valid_o  = 1'b0;
    done_o        = 1'b0;
    busy_o        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_blk_tgt_nxt = (num_blocks_i == '0) ? BLK_CNT_W'(1) : num_blocks_i;
          w_blk_cnt_nxt = '0;
          w_state_nxt   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_clear_o = 1'b1;
        w_state_nxt   = S_ABSORB;
      end
      S_ABSORB: begin
        din_ready_o  = 1'b1;
        absorb_en_o  = din_valid_i;
        absorb_sel_o = r_lane;
        if (din_valid_i) begin
          if (w_last_lane) begin
            w_lane_nxt  = '0;
            w_state_nxt = S_PERMUTE;
          end else begin
            w_lane_nxt = r_lane + 5'd1;
          end
        end
      end
      S_PERMUTE: begin
        round_en_o  = 1'b1;
        round_idx_o = r_round;
        if (w_last_round) begin
          w_round_nxt = '0;
          w_state_nxt = S_SQUEEZE;
        end else begin
          w_round_nxt = r_round + CNT_LENGTH_ROUND'(1);
        end
      end
      S_SQUEEZE: begin
        dout_valid_o = 1'b1;
        if (dout_ready_i) begin
          if (w_last_blk) begin
            w_state_nxt = S_DONE;
          end else begin
            w_blk_cnt_nxt = r_blk_cnt + BLK_CNT_W'(1);
            w_state_nxt   = S_PERMUTE;
          end
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Self-checking bench for keccak_sponge_ctrl: procedural pass model checked every cycle,
// plus literal latency/count expectations for directed sponge passes.
module tb_keccak_sponge_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] num_blocks_i = '0;
  logic        din_valid_i = 1'b0;
  logic        dout_ready_i = 1'b0;
  logic        din_ready_o, state_clear_o, absorb_en_o, round_en_o;
  logic        dout_valid_o, busy_o, done_o;
  logic [4:0]  absorb_sel_o, round_idx_o;

  keccak_sponge_ctrl dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .num_blocks_i(num_blocks_i),
    .din_valid_i(din_valid_i), .din_ready_o(din_ready_o), .state_clear_o(state_clear_o),
    .absorb_en_o(absorb_en_o), .absorb_sel_o(absorb_sel_o), .round_en_o(round_en_o),
    .round_idx_o(round_idx_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  wire [16:0] act_vec = {state_clear_o, din_ready_o, absorb_en_o, absorb_sel_o,
                         round_en_o, round_idx_o, dout_valid_o, busy_o, done_o};

  function automatic logic [16:0] mk(bit clr, bit dr, bit ab, int sel, bit ren, int ridx,
                                     bit dv, bit busy, bit done);
    return {clr, dr, ab, 5'(sel), ren, 5'(ridx), dv, busy, done};
  endfunction

  task automatic chk_vec(input string nm, input logic [16:0] e);
    n_chk++;
    if (act_vec !== e) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h at t=%0t", nm, act_vec, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int e);
    n_chk++;
    if (act != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, e, $time);
    end
  endtask

  // ---------------- behavioural pass model, compared every cycle ----------------
  task automatic step(input int ph, input int idx, output bit ok, output bit hs);
    logic [16:0] e;
    string nm;
    @(negedge clk);
    hs = 1'b0;
    if (!resetn) begin
      ok = 1'b0;
      chk_vec("model_reset", '0);
    end else begin
      ok = 1'b1;
      case (ph)
        1: begin e = mk(1,0,0,0,0,0,0,1,0); nm = "model_clear"; end
        2: begin e = mk(0,1,din_valid_i,idx,0,0,0,1,0); hs = din_valid_i; nm = "model_absorb"; end
        3: begin e = mk(0,0,0,0,1,idx,0,1,0); nm = "model_permute"; end
        4: begin e = mk(0,0,0,0,0,0,1,1,0); hs = dout_ready_i; nm = "model_squeeze"; end
        default: begin e = mk(0,0,0,0,0,0,0,1,1); nm = "model_done"; end
      endcase
      chk_vec(nm, e);
    end
  endtask

  initial begin : model
    bit ok, hs, go;
    int tgt, lane;
    forever begin
      go = 1'b0;
      tgt = 1;
      while (!go) begin
        @(negedge clk);
        chk_vec("model_idle", '0);
        go  = resetn && start_i;
        tgt = (num_blocks_i == 16'd0) ? 1 : int'(num_blocks_i);
      end
      step(1, 0, ok, hs);
      lane = 0;
      while (ok && lane < 21) begin
        step(2, lane, ok, hs);
        if (hs) lane++;
      end
      for (int b = 0; ok && b < tgt; b++) begin
        for (int r = 0; ok && r < 24; r++) step(3, r, ok, hs);
        hs = 1'b0;
        while (ok && !hs) step(4, 0, ok, hs);
      end
      if (ok) step(5, 0, ok, hs);
    end
  end

  // ---------------- event monitor for literal expectations ----------------
  int t_start, first_dv, done_cyc, n_abs, abs_bad, n_ren, n_hs, n_done, last_hs, stall_dv;
  int gaps[$];

  task automatic mon_clear();
    first_dv = -1; done_cyc = -1; n_abs = 0; abs_bad = 0; n_ren = 0;
    n_hs = 0; n_done = 0; last_hs = -1; stall_dv = 0;
    gaps.delete();
  endtask

  always @(negedge clk) begin
    if (absorb_en_o) begin
      if (absorb_sel_o != 5'(n_abs)) abs_bad++;
      n_abs++;
    end
    if (round_en_o) n_ren++;
    if (dout_valid_o) begin
      if (first_dv < 0) first_dv = edge_cnt - t_start;
      if (dout_ready_i) begin
        if (last_hs >= 0) gaps.push_back(edge_cnt - last_hs);
        last_hs = edge_cnt;
        n_hs++;
      end else begin
        stall_dv++;
      end
    end
    if (done_o) begin
      n_done++;
      done_cyc = edge_cnt - t_start;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int nb, input bit vtog, input int stall,
                          input bit poke, input bit abort);
    bit finished;
    int k, stall_left;
    mon_clear();
    stall_left   = stall;
    num_blocks_i = 16'(nb);
    start_i      = 1'b1;
    t_start      = edge_cnt;
    cyc();
    start_i  = 1'b0;
    finished = 1'b0;
    k = 0;
    while (!finished && k < 4000) begin
      if (abort && round_en_o && round_idx_o == 5'd10) begin
        #1 resetn = 1'b0;
        #1 chk_vec("abort_outputs_zero", '0);
        cyc();
        resetn   = 1'b1;
        finished = 1'b1;
      end else begin
        din_valid_i = vtog ? (k % 2 == 0) : 1'b1;
        if (dout_valid_o && stall_left > 0) begin
          dout_ready_i = 1'b0;
          stall_left--;
        end else begin
          dout_ready_i = 1'b1;
        end
        start_i = poke && (k == 5 || done_o);
        if (done_o) finished = 1'b1;
        cyc();
        start_i = 1'b0;
        k++;
      end
    end
    if (!finished) chk_int("pass_timeout", k, -1);
    chk_int("busy_after_pass", busy_o, 0);
    repeat (3) cyc();
  endtask

  initial begin
    mon_clear();
    t_start = 0;
    repeat (3) cyc();
    chk_vec("reset_outputs", '0);
    resetn = 1'b1;
    repeat (2) cyc();
    chk_vec("idle_after_reset", '0);

    // T1
    run_pass(1, 0, 0, 0, 0);
    chk_int("t1_first_dv", first_dv, 47);
    chk_int("t1_done_cyc", done_cyc, 48);
    chk_int("t1_absorbs", n_abs, 21);
    chk_int("t1_abs_order", abs_bad, 0);
    chk_int("t1_rounds", n_ren, 24);
    chk_int("t1_out_hs", n_hs, 1);
    chk_int("t1_done_cnt", n_done, 1);

    // T2
    run_pass(3, 0, 0, 0, 0);
    chk_int("t2_out_hs", n_hs, 3);
    chk_int("t2_rounds", n_ren, 72);
    chk_int("t2_gap_cnt", gaps.size(), 2);
    foreach (gaps[i]) chk_int("t2_gap", gaps[i], 25);
    chk_int("t2_done_cyc", done_cyc, 98);

    // T3
    run_pass(1, 1, 0, 0, 0);
    chk_int("t3_absorbs", n_abs, 21);
    chk_int("t3_abs_order", abs_bad, 0);
    chk_int("t3_first_dv", first_dv, 68);
    chk_int("t3_done_cyc", done_cyc, 69);

    // T4
    run_pass(1, 0, 10, 0, 0);
    chk_int("t4_stall_dv", stall_dv, 10);
    chk_int("t4_first_dv", first_dv, 47);
    chk_int("t4_rounds", n_ren, 24);
    chk_int("t4_done_cyc", done_cyc, 58);

    // T5
    run_pass(0, 0, 0, 1, 0);
    chk_int("t5_first_dv", first_dv, 47);
    chk_int("t5_done_cyc", done_cyc, 48);
    chk_int("t5_done_cnt", n_done, 1);
    chk_int("t5_out_hs", n_hs, 1);

    // T6
    run_pass(2, 0, 0, 0, 1);
    chk_int("t6_no_done", n_done, 0);
    chk_int("t6_rounds_before_abort", n_ren, 10);
    run_pass(1, 0, 0, 0, 0);
    chk_int("t6_rerun_first_dv", first_dv, 47);
    chk_int("t6_rerun_done_cyc", done_cyc, 48);
    chk_int("t6_rerun_absorbs", n_abs, 21);
    chk_int("t6_rerun_done_cnt", n_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
